// File: rtl/main_mem_responder.sv
// main_mem_responder: memory-side end of the cache miss/write-back interface
//   Accepts single-word writes and aligned 16-word line reads. Each request gets one
//   main_mem_ready pulse after a fixed access latency.
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     main_mem_addr       byte address; word index = addr[MEM_WORDS_LOG2+1:2]
//     main_mem_data_out   write word from the controller
//     main_mem_read_req   line read request (level)
//     main_mem_write_req  word write request (level)
//     main_mem_data_in    returned line, word i at [32*i+31:32*i]
//     main_mem_ready      one-cycle completion pulse
//     main_mem_busy       high whenever the responder is not idle
module main_mem_responder #(
    parameter int          MEM_WORDS_LOG2 = 12,
    parameter int          LATENCY        = 4,
    parameter logic [31:0] INIT_WORD      = 32'h0000_0001
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  main_mem_addr,
    input  logic [31:0]  main_mem_data_out,
    input  logic         main_mem_read_req,
    input  logic         main_mem_write_req,
    output logic [511:0] main_mem_data_in,
    output logic         main_mem_ready,
    output logic         main_mem_busy
);
    localparam int AW = MEM_WORDS_LOG2;

    typedef enum logic [2:0] {IDLE, WAIT, FILL, ACK, RELEASE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [3:0]     beat_q, beat_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           rd_q, rd_d;
    logic           ready_q, ready_d;
    logic [511:0]   line_q, line_d;
    logic [511:0]   data_q, data_d;
    logic           mem_we;
    logic [31:0]    mem_rd;
    logic           unused_addr_bits;

    // Words are kept XOR-ed with INIT_WORD so that zeroed power-up storage reads
    // back as INIT_WORD without any reset or initialisation of the array.
    logic [31:0]    storage_q [2**AW];

    assign unused_addr_bits = ^{main_mem_addr[31:AW+2], main_mem_addr[1:0]};
    assign mem_rd           = storage_q[{idx_q[AW-1:4], beat_q}] ^ INIT_WORD;

    assign main_mem_data_in = data_q;
    assign main_mem_ready   = ready_q;
    assign main_mem_busy    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        line_d  = line_q;
        data_d  = data_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // read wins when both are requested; the write word is not latched
                if (main_mem_read_req || main_mem_write_req) begin
                    idx_d   = main_mem_addr[AW+1:2];
                    rd_d    = main_mem_read_req;
                    wdata_d = main_mem_read_req ? wdata_q : main_mem_data_out;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'(LATENCY - 1)) begin
                    mem_we  = !rd_q;
                    beat_d  = 4'd0;
                    state_d = rd_q ? FILL : ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FILL: begin
                line_d[32*beat_q +: 32] = mem_rd;
                beat_d  = beat_q + 4'd1;
                state_d = (beat_q == 4'd15) ? ACK : FILL;
            end
            ACK: begin
                ready_d = 1'b1;
                data_d  = rd_q ? line_q : data_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                // wait for the controller to drop its request so it is not re-accepted
                state_d = (main_mem_read_req || main_mem_write_req) ? RELEASE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            ready_q <= 1'b0;
            line_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            line_q  <= line_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) storage_q[idx_q] <= wdata_q ^ INIT_WORD;
    end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed self-checking bench for main_mem_responder
module tb_main_mem_responder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;
    logic         main_mem_busy;

    int passed = 0;
    int total  = 0;

    main_mem_responder dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .main_mem_addr      (main_mem_addr),
        .main_mem_data_out  (main_mem_data_out),
        .main_mem_read_req  (main_mem_read_req),
        .main_mem_write_req (main_mem_write_req),
        .main_mem_data_in   (main_mem_data_in),
        .main_mem_ready     (main_mem_ready),
        .main_mem_busy      (main_mem_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] line_of(input logic [31:0] w1, input logic [31:0] w2);
        logic [511:0] l;
        l = {16{32'h0000_0001}};
        l[63:32] = w1;
        l[95:64] = w2;
        return l;
    endfunction

    // Drives one request starting at the next edge (edge 0 = accept), scrambles the
    // address/data after accept, drops the request once ready is seen, and reports
    // the edge at which ready was first high plus the number of ready pulses.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output int pulses,
                           output logic busy1);
        lat = -1;
        pulses = 0;
        busy1 = 1'b0;
        main_mem_addr = a;
        main_mem_data_out = d;
        main_mem_read_req = rd;
        main_mem_write_req = wr;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                busy1 = main_mem_busy;
                main_mem_addr = 32'hFFFF_FFFC;
                main_mem_data_out = 32'h0BAD_0BAD;
            end
            if (main_mem_ready) begin
                pulses++;
                if (lat < 0) lat = e;
                main_mem_read_req = 1'b0;
                main_mem_write_req = 1'b0;
            end
        end
        main_mem_read_req = 1'b0;
        main_mem_write_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        main_mem_addr = '0;
        main_mem_data_out = '0;
        main_mem_read_req = 1'b0;
        main_mem_write_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (main_mem_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", main_mem_ready); else passed++;
        total++; if (main_mem_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", main_mem_busy); else passed++;
        total++; if (main_mem_data_in !== 512'd0) $display("FAIL reset_data: got %h want 0", main_mem_data_in); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_init;
        int lat, pulses;
        logic busy1;
        run_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, pulses, busy1);
        total++; if (busy1 !== 1'b1) $display("FAIL read_init_busy: got %b want 1", busy1); else passed++;
        total++; if (lat != 21) $display("FAIL read_init_latency: got %0d want 21", lat); else passed++;
        total++; if (pulses != 1) $display("FAIL read_init_pulses: got %0d want 1", pulses); else passed++;
        total++; if (main_mem_data_in !== {16{32'h0000_0001}}) $display("FAIL read_init_data: got %h want %h", main_mem_data_in, {16{32'h0000_0001}}); else passed++;
        total++; if (main_mem_busy !== 1'b0) $display("FAIL read_init_idle: got %b want 0", main_mem_busy); else passed++;
    endtask

    task automatic test_write;
        int lat, pulses;
        logic busy1;
        run_req(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, lat, pulses, busy1);
        total++; if (lat != 5) $display("FAIL write_latency: got %0d want 5", lat); else passed++;
        total++; if (pulses != 1) $display("FAIL write_pulses: got %0d want 1", pulses); else passed++;
        total++; if (main_mem_data_in !== {16{32'h0000_0001}}) $display("FAIL write_data_untouched: got %h want %h", main_mem_data_in, {16{32'h0000_0001}}); else passed++;
        run_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, pulses, busy1);
        total++; if (lat != 21) $display("FAIL write_readback_latency: got %0d want 21", lat); else passed++;
        total++; if (main_mem_data_in !== line_of(32'hDEAD_BEEF, 32'h1)) $display("FAIL write_readback_data: got %h want %h", main_mem_data_in, line_of(32'hDEAD_BEEF, 32'h1)); else passed++;
    endtask

    task automatic test_alias;
        int lat, pulses;
        logic busy1;
        run_req(1'b0, 1'b1, 32'h0001_0048, 32'hCAFE_F00D, lat, pulses, busy1);
        total++; if (lat != 5) $display("FAIL alias_write_latency: got %0d want 5", lat); else passed++;
        run_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, pulses, busy1);
        total++; if (main_mem_data_in !== line_of(32'hDEAD_BEEF, 32'hCAFE_F00D)) $display("FAIL alias_data: got %h want %h", main_mem_data_in, line_of(32'hDEAD_BEEF, 32'hCAFE_F00D)); else passed++;
        run_req(1'b1, 1'b0, 32'h0000_007E, 32'h0, lat, pulses, busy1);
        total++; if (main_mem_data_in !== line_of(32'hDEAD_BEEF, 32'hCAFE_F00D)) $display("FAIL unaligned_line_data: got %h want %h", main_mem_data_in, line_of(32'hDEAD_BEEF, 32'hCAFE_F00D)); else passed++;
    endtask

    task automatic test_both;
        int lat, pulses;
        logic busy1;
        run_req(1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678, lat, pulses, busy1);
        total++; if (lat != 21) $display("FAIL both_latency: got %0d want 21", lat); else passed++;
        total++; if (pulses != 1) $display("FAIL both_pulses: got %0d want 1", pulses); else passed++;
        run_req(1'b1, 1'b0, 32'h0000_0080, 32'h0, lat, pulses, busy1);
        total++; if (main_mem_data_in !== {16{32'h0000_0001}}) $display("FAIL both_no_write: got %h want %h", main_mem_data_in, {16{32'h0000_0001}}); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat, pulses;
        logic busy1;
        lat = -1;
        pulses = 0;
        main_mem_addr = 32'h0000_0040;
        main_mem_read_req = 1'b1;
        for (int e = 0; e < 32; e++) begin
            @(posedge clk); #1;
            if (main_mem_ready) begin
                pulses++;
                if (lat < 0) lat = e;
            end
        end
        total++; if (lat != 21) $display("FAIL hold_latency: got %0d want 21", lat); else passed++;
        total++; if (pulses != 1) $display("FAIL hold_pulses: got %0d want 1", pulses); else passed++;
        total++; if (main_mem_busy !== 1'b1) $display("FAIL hold_busy_release: got %b want 1", main_mem_busy); else passed++;
        main_mem_read_req = 1'b0;
        @(posedge clk); #1;
        total++; if (main_mem_busy !== 1'b0) $display("FAIL hold_idle_after_drop: got %b want 0", main_mem_busy); else passed++;
        run_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, pulses, busy1);
        total++; if (lat != 21) $display("FAIL reassert_latency: got %0d want 21", lat); else passed++;
        total++; if (pulses != 1) $display("FAIL reassert_pulses: got %0d want 1", pulses); else passed++;
    endtask

    task automatic test_reset_mid;
        int lat, pulses;
        logic busy1;
        pulses = 0;
        main_mem_addr = 32'h0000_0040;
        main_mem_read_req = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (main_mem_ready) pulses++;
        end
        rst_n = 1'b0;
        #1;
        total++; if (main_mem_ready !== 1'b0) $display("FAIL midreset_ready: got %b want 0", main_mem_ready); else passed++;
        total++; if (main_mem_busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", main_mem_busy); else passed++;
        total++; if (main_mem_data_in !== 512'd0) $display("FAIL midreset_data: got %h want 0", main_mem_data_in); else passed++;
        main_mem_read_req = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            if (main_mem_ready) pulses++;
        end
        rst_n = 1'b1;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk); #1;
            if (main_mem_ready) pulses++;
        end
        total++; if (pulses != 0) $display("FAIL midreset_no_pulse: got %0d want 0", pulses); else passed++;
        run_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, pulses, busy1);
        total++; if (lat != 21) $display("FAIL postreset_latency: got %0d want 21", lat); else passed++;
        total++; if (main_mem_data_in !== line_of(32'hDEAD_BEEF, 32'hCAFE_F00D)) $display("FAIL postreset_data: got %h want %h", main_mem_data_in, line_of(32'hDEAD_BEEF, 32'hCAFE_F00D)); else passed++;
    endtask

    initial begin
        test_reset();
        test_read_init();
        test_write();
        test_alias();
        test_both();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
